ifq: RTL and testbench
======================

// Module: ifq
// PURPOSE
// - Instruction fetch queue between the fetch unit and the decoder (du).
// - Buffers {pc, instr, fault} from fetch with valid/ready on both sides.
// - Decouples fetch stalls from decode/issue stalls.
// - Discards all held entries in one cycle on pipeline flush (branch redirect, fence.i, trap).
// PARAMETERS
// - DEPTH  4   number of entries; power of two, >= 2
// - CNT_W  3   count width = $clog2(DEPTH)+1
// PORTS
// - clk        in   1      clock, all state updates on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - if_pc      in   64     PC of the fetched instruction
// - if_instr   in   32     fetched instruction word
// - if_fault   in   1      instruction access fault on this fetch
// - if_valid   in   1      fetch presents an entry
// - if_ready   out  1      queue accepts an entry this cycle
// - dec_pc     out  64     head entry PC
// - dec_instr  out  32     head entry instruction; drives du.instr
// - dec_fault  out  1      head entry fault flag
// - dec_valid  out  1      head entry valid
// - dec_ready  in   1      decoder/issue consumes the head this cycle
// - flush      in   1      discard all entries
// - count      out  CNT_W  current number of valid entries, 0..DEPTH
// BEHAVIOUR
// - State:
//   - circular storage of DEPTH x {pc, instr, fault}
//   - wr_ptr, rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH
//   - count register
// - Reset (rst_n low, async):
//   - wr_ptr = rd_ptr = count = 0
//   - dec_valid = 0, if_ready = 1
//   - dec_pc = 0, dec_instr = 32'h00000013 (NOP), dec_fault = 0
//   - Storage contents are not reset.
// - Status outputs:
//   - if_ready = (count != DEPTH), derived from the registered count only; no dependence on dec_ready.
//   - dec_valid = (count != 0).
// - Handshakes:
//   - push = if_valid & if_ready & ~flush
//   - pop = dec_valid & dec_ready & ~flush
// - Latency and ordering:
//   - No bypass. An entry pushed at edge N is first visible on dec_* in the cycle after N.
//   - Minimum latency is 1 cycle.
//   - Entries are delivered strictly in push order.
// - Empty-queue outputs: when count == 0, dec_pc = 0, dec_instr = NOP, dec_fault = 0.
// - Count update:
//   - push only: count + 1
//   - pop only: count - 1
//   - push and pop together: count unchanged, both pointers advance
//   - Simultaneous push and pop is legal at any count except full, where if_ready = 0 blocks the push.
// - Full (count == DEPTH):
//   - if_ready = 0; fetch must hold its entry.
//   - A pop in the full cycle frees one slot, so if_ready = 1 next cycle.
// - Empty (count == 0): dec_ready is ignored and nothing is popped.
// - Flush:
//   - Has priority over push and pop.
//   - Next edge: wr_ptr = rd_ptr = count = 0.
//   - Any handshake in the flush cycle is discarded.
//   - dec_valid = 0 in the following cycle.
//   - A push is accepted in the cycle right after flush.
// - Pointer wrap: pointers roll DEPTH-1 -> 0 with no bubble.
// - Fault entries are queued and delivered like normal entries; the queue does not interpret them.
// - Reset asserted mid-operation: all held entries are dropped immediately.
// TESTING
// - Reset, then push pc=0x80000000 instr=0x00100093, dec_ready=1:
//   dec_valid=1 exactly one cycle after the push, then count returns 0.
// - Push 4 entries with dec_ready=0:
//   count=4, if_ready=0; a 5th if_valid is held; then pop 1 -> if_ready=1 next cycle.
// - Continuous push+pop at count=2 for 10 cycles with PCs 0x0,0x4,...:
//   count stays 2, order preserved across pointer wrap.
// - Count=3, flush asserted together with if_valid and dec_ready:
//   next cycle count=0, dec_valid=0, dec_instr=0x00000013; pushed entry lost.
// - Push with if_fault=1 at pc=0x1000:
//   dec_fault=1 with dec_pc=0x1000; the next entry has dec_fault=0.
// - rst_n pulsed low mid-stream with count=3:
//   outputs immediately at reset values; first post-reset push delivered correctly.

Source files
------------

// File: rtl/ifq.sv
// Instruction fetch queue: circular buffer of {pc, instr, fault} between fetch and decode.
// Single-cycle flush; no bypass, so a pushed entry is visible on dec_* one cycle later.
module ifq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      if_pc,
    input  logic [31:0]      if_instr,
    input  logic             if_fault,
    input  logic             if_valid,
    output logic             if_ready,
    output logic [63:0]      dec_pc,
    output logic [31:0]      dec_instr,
    output logic             dec_fault,
    output logic             dec_valid,
    input  logic             dec_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign count     = count_q;
    assign if_ready  = (count_q != CNT_W'(DEPTH));
    assign dec_valid = (count_q != '0);
    assign push      = if_valid & if_ready & ~flush;
    assign pop       = dec_valid & dec_ready & ~flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: if_pc, instr: if_instr, fault: if_fault};
    end

    // Empty queue presents a NOP so decode never sees stale storage.
    always_comb begin
        dec_pc    = '0;
        dec_instr = NOP;
        dec_fault = 1'b0;
        if (dec_valid) begin
            dec_pc    = mem[rd_ptr].pc;
            dec_instr = mem[rd_ptr].instr;
            dec_fault = mem[rd_ptr].fault;
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: driver feeds a reference queue of accepted entries,
// a negedge monitor compares DUT status and head entry against it.
module tb_ifq;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        if_fault = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [63:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_fault;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    ifq #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_instr(if_instr), .if_fault(if_fault),
        .if_valid(if_valid), .if_ready(if_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_fault(dec_fault),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   last_acc = 1'b0;
    ent_t last_ent;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an entry enters the queue at the edge after it was offered and accepted.
    task automatic step(input bit v, input ent_t e, input bit rdy, input bit fl);
        @(posedge clk);
        #1;
        if (last_acc) mq.push_back(last_ent);
        if_valid  = v;
        if_pc     = e.pc;
        if_instr  = e.instr;
        if_fault  = e.fault;
        dec_ready = rdy;
        flush     = fl;
        last_acc  = v && !fl && (mq.size() < DEPTH);
        last_ent  = e;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_dec_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd1);
        chk({tag, "_dec_pc"}, dec_pc, 64'd0);
        chk({tag, "_dec_instr"}, 64'(dec_instr), 64'(NOP));
        chk({tag, "_dec_fault"}, 64'(dec_fault), 64'd0);
    endtask

    function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] instr, input logic f);
        ent_t e;
        e.pc = pc; e.instr = instr; e.fault = f;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("if_ready", 64'(if_ready), 64'(mq.size() < DEPTH));
            chk("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("head_pc", dec_pc, mq[0].pc);
                chk("head_instr", 64'(dec_instr), 64'(mq[0].instr));
                chk("head_fault", 64'(dec_fault), 64'(mq[0].fault));
            end else begin
                chk("empty_pc", dec_pc, 64'd0);
                chk("empty_instr", 64'(dec_instr), 64'(NOP));
                chk("empty_fault", 64'(dec_fault), 64'd0);
            end
            if (flush) mq.delete();
            else if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
        end
    end

    initial begin
        ent_t e;
        bit   v;
        #2;
        check_reset_outputs("por");
        #10 rst_n = 1'b1;

        // Single push with decoder ready.
        step(1'b1, mk(64'h8000_0000, 32'h0010_0093, 1'b0), 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Fill to full, hold a fifth entry, then pop one.
        for (int i = 0; i < 4; i++) step(1'b1, mk(64'h100 + 64'(i * 4), 32'(i + 1), 1'b0), 1'b0, 1'b0);
        repeat (3) step(1'b1, mk(64'h200, 32'hDEAD_0005, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(64'h200, 32'hDEAD_0005, 1'b0), 1'b1, 1'b0);
        repeat (2) step(1'b1, mk(64'h200, 32'hDEAD_0005, 1'b0), 1'b0, 1'b0);
        repeat (8) idle(1'b1);

        // Streaming at count 2 across pointer wrap.
        step(1'b1, mk(64'h0, 32'hA000_0000, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(64'h4, 32'hA000_0001, 1'b0), 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) step(1'b1, mk(64'(i * 4), 32'hA000_0000 + 32'(i), 1'b0), 1'b1, 1'b0);
        repeat (4) idle(1'b1);

        // Flush at count 3 with push and pop offered, then push right after.
        for (int i = 0; i < 3; i++) step(1'b1, mk(64'h300 + 64'(i * 4), 32'hB000_0000 + 32'(i), 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(64'h3FC, 32'hBAD0_0000, 1'b0), 1'b1, 1'b1);
        step(1'b1, mk(64'h400, 32'hC000_0000, 1'b0), 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Fault entry followed by a normal one.
        step(1'b1, mk(64'h1000, 32'h0000_0073, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(64'h1004, 32'h0000_0013, 1'b0), 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) step(1'b1, mk(64'h500 + 64'(i * 4), 32'hD000_0000 + 32'(i), 1'b0), 1'b0, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #1;
        if (last_acc) mq.push_back(last_ent);
        if_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        mq.delete();
        last_acc = 1'b0;
        #1 check_reset_outputs("mid_rst");
        #1 rst_n = 1'b1;
        step(1'b1, mk(64'h600, 32'hE000_0000, 1'b0), 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // Randomized traffic; fetch holds an offered entry until it is taken.
        v = 1'b0;
        e = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!v || last_acc) begin
                v = ($urandom_range(0, 3) != 0);
                e = mk({$urandom, $urandom}, $urandom, ($urandom_range(0, 7) == 0));
            end
            step(v, e, ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        repeat (8) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
